// File: rtl/reset_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer_if
// Brief    : Request inputs and reset/halt pin outputs of the reset sequencer.
// Revision : 1.0  initial release
// ============================================================================
interface reset_sequencer_if;
    logic       TICK;
    logic       WD_EXPIRE;
    logic       SOFT_RST;
    logic       nRESET;
    logic       nHALT;
    logic       nZ80RESET;
    logic       WD_CLEAR;
    logic       SEQ_BUSY;
    logic [1:0] RST_CAUSE;

    // master: timebase/watchdog/CPU-pin side; slave: the sequencer itself
    modport master (
        output TICK, WD_EXPIRE, SOFT_RST,
        input  nRESET, nHALT, nZ80RESET, WD_CLEAR, SEQ_BUSY, RST_CAUSE
    );

    modport slave (
        input  TICK, WD_EXPIRE, SOFT_RST,
        output nRESET, nHALT, nZ80RESET, WD_CLEAR, SEQ_BUSY, RST_CAUSE
    );
endinterface
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : reset_sequencer
// Brief    : Power-on / watchdog / soft reset sequencing for the 68K and Z80.
// Revision : 1.0  initial release
// ============================================================================
module reset_sequencer #(
    parameter int POR_CYCLES = 1024,
    parameter int RST_PULSE  = 16,
    parameter int Z80_DELAY  = 8,
    parameter int CNT_W      = 11
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    reset_sequencer_if.slave  bus
);

    localparam logic [1:0] c_st_por    = 2'd0;
    localparam logic [1:0] c_st_run    = 2'd1;
    localparam logic [1:0] c_st_assert = 2'd2;
    localparam logic [1:0] c_st_rel68k = 2'd3;

    localparam logic [1:0] c_cause_por  = 2'd0;
    localparam logic [1:0] c_cause_soft = 2'd1;
    localparam logic [1:0] c_cause_wd   = 2'd2;

    // Terminal count of each timed state: exit on the TICK where CNT == L-1
    localparam logic [CNT_W-1:0] c_por_last   = CNT_W'(POR_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_pulse_last = CNT_W'(RST_PULSE - 1);
    localparam logic [CNT_W-1:0] c_z80_last   = CNT_W'(Z80_DELAY - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cause;
    logic             r_wd_prev;

    logic [1:0]       w_state_nxt;
    logic             w_cnt_clr;
    logic             w_wd_rise;
    logic             w_start_seq;

    assign w_wd_rise   = bus.WD_EXPIRE & ~r_wd_prev;
    assign w_start_seq = (r_state == c_st_run) && (w_wd_rise || bus.SOFT_RST);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_clr   = 1'b0;
        case (r_state)
            c_st_por: begin
                if (bus.TICK && (r_cnt == c_por_last)) begin
                    w_state_nxt = c_st_rel68k;
                    w_cnt_clr   = 1'b1;
                end
            end
            c_st_assert: begin
                if (bus.TICK && (r_cnt == c_pulse_last)) begin
                    w_state_nxt = c_st_rel68k;
                    w_cnt_clr   = 1'b1;
                end
            end
            c_st_rel68k: begin
                if (bus.TICK && (r_cnt == c_z80_last)) begin
                    w_state_nxt = c_st_run;
                    w_cnt_clr   = 1'b1;
                end
            end
            c_st_run: begin
                if (w_start_seq) begin
                    w_state_nxt = c_st_assert;
                    w_cnt_clr   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = c_st_por;
                w_cnt_clr   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_st_por;
            r_cnt     <= '0;
            r_cause   <= c_cause_por;
            r_wd_prev <= 1'b0;
        end else begin
            // Edge history tracks WD_EXPIRE in every state, so a level still
            // high on return to RUN cannot retrigger a sequence.
            r_wd_prev <= bus.WD_EXPIRE;
            r_state   <= w_state_nxt;
            if (w_cnt_clr || (r_state == c_st_run)) begin
                r_cnt <= '0;
            end else if (bus.TICK) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_start_seq) begin
                r_cause <= w_wd_rise ? c_cause_wd : c_cause_soft;
            end
        end
    end

    // Pin levels depend on the state register alone, so they cannot glitch
    assign bus.nRESET    = (r_state == c_st_run) || (r_state == c_st_rel68k);
    assign bus.nHALT     = (r_state == c_st_run) || (r_state == c_st_rel68k);
    assign bus.nZ80RESET = (r_state == c_st_run);
    assign bus.WD_CLEAR  = (r_state != c_st_run);
    assign bus.SEQ_BUSY  = (r_state != c_st_run);
    assign bus.RST_CAUSE = r_cause;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reset_sequencer
// Brief    : Scoreboard bench: expected pin-change events vs. observed ones.
// Revision : 1.0  initial release
// ============================================================================
module tb_reset_sequencer;

    typedef struct {
        int         edge_no;
        logic [6:0] vec;
    } exp_t;

    // {nRESET, nHALT, nZ80RESET, WD_CLEAR, SEQ_BUSY} for each state
    localparam logic [4:0] c_v_hold = 5'b000_11;
    localparam logic [4:0] c_v_rel  = 5'b110_11;
    localparam logic [4:0] c_v_run  = 5'b111_00;

    logic CLK;
    logic RST;
    int   edge_n;
    int   errors;
    int   checks;
    exp_t exp_q[$];

    reset_sequencer_if bus();

    reset_sequencer #(
        .POR_CYCLES (4),
        .RST_PULSE  (3),
        .Z80_DELAY  (2),
        .CNT_W      (11)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        edge_n = 0;
        forever begin
            @(posedge CLK);
            edge_n++;
        end
    end

    // TICK is sampled high on every even-numbered edge
    initial begin
        bus.TICK = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            bus.TICK = ((edge_n + 1) % 2 == 0);
        end
    end

    task automatic expect_ev(input int e, input logic [4:0] pins, input logic [1:0] cause);
        exp_t item;
        item.edge_no = e;
        item.vec     = {pins, cause};
        exp_q.push_back(item);
    endtask

    // Returns just after edge e-1, so inputs set next are sampled at edge e
    task automatic at_edge(input int e);
        while (edge_n < e - 1) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Monitor: every change of the pin vector must match the next expected event
    initial begin
        logic [6:0] prev;
        logic [6:0] cur;
        exp_t       item;
        prev = 'x;
        forever begin
            @(negedge CLK);
            if (edge_n >= 1) begin
                cur = {bus.nRESET, bus.nHALT, bus.nZ80RESET, bus.WD_CLEAR,
                       bus.SEQ_BUSY, bus.RST_CAUSE};
                if (cur !== prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: edge %0d pins %b, required no change",
                                 edge_n, cur);
                    end else begin
                        item = exp_q.pop_front();
                        if (item.edge_no != edge_n || item.vec !== cur) begin
                            errors++;
                            $display("FAIL event_at_edge_%0d: got edge %0d pins %b, required edge %0d pins %b",
                                     item.edge_no, edge_n, cur, item.edge_no, item.vec);
                        end
                    end
                    prev = cur;
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        errors        = 0;
        checks        = 0;
        RST           = 1'b1;
        bus.WD_EXPIRE = 1'b0;
        bus.SOFT_RST  = 1'b0;

        // Power-on: RST high at edges 1..3, POR TICKs 4,6,8,10, Z80 at 14
        expect_ev(1,  c_v_hold, 2'd0);
        expect_ev(10, c_v_rel,  2'd0);
        expect_ev(14, c_v_run,  2'd0);
        at_edge(4);
        RST = 1'b0;

        // Watchdog rise at edge 20 (TICK edge): ASSERT TICKs 22,24,26
        expect_ev(20, c_v_hold, 2'd2);
        expect_ev(26, c_v_rel,  2'd2);
        expect_ev(30, c_v_run,  2'd2);
        at_edge(20);
        bus.WD_EXPIRE = 1'b1;
        at_edge(40);
        bus.WD_EXPIRE = 1'b0;

        // Soft reset, one-CLK pulse at odd edge 45
        expect_ev(45, c_v_hold, 2'd1);
        expect_ev(50, c_v_rel,  2'd1);
        expect_ev(54, c_v_run,  2'd1);
        at_edge(45);
        bus.SOFT_RST = 1'b1;
        at_edge(46);
        bus.SOFT_RST = 1'b0;

        // Simultaneous watchdog rise and soft request: watchdog cause wins
        expect_ev(60, c_v_hold, 2'd2);
        expect_ev(66, c_v_rel,  2'd2);
        expect_ev(70, c_v_run,  2'd2);
        at_edge(60);
        bus.WD_EXPIRE = 1'b1;
        bus.SOFT_RST  = 1'b1;
        at_edge(61);
        bus.SOFT_RST  = 1'b0;
        at_edge(75);
        bus.WD_EXPIRE = 1'b0;

        // Requests during ASSERT are dropped; WD still high on return to RUN
        expect_ev(80, c_v_hold, 2'd1);
        expect_ev(86, c_v_rel,  2'd1);
        expect_ev(90, c_v_run,  2'd1);
        at_edge(80);
        bus.SOFT_RST  = 1'b1;
        at_edge(81);
        bus.SOFT_RST  = 1'b0;
        at_edge(82);
        bus.WD_EXPIRE = 1'b1;
        at_edge(83);
        bus.SOFT_RST  = 1'b1;
        at_edge(84);
        bus.SOFT_RST  = 1'b0;
        at_edge(95);
        bus.WD_EXPIRE = 1'b0;

        // RST during REL68K at edge 107 restarts a full POR: TICKs 108..114
        expect_ev(100, c_v_hold, 2'd1);
        expect_ev(106, c_v_rel,  2'd1);
        expect_ev(107, c_v_hold, 2'd0);
        expect_ev(114, c_v_rel,  2'd0);
        expect_ev(118, c_v_run,  2'd0);
        at_edge(100);
        bus.SOFT_RST = 1'b1;
        at_edge(101);
        bus.SOFT_RST = 1'b0;
        at_edge(107);
        RST = 1'b1;
        at_edge(108);
        RST = 1'b0;

        at_edge(130);
        @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d expected events not observed, required 0",
                     exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
